// File: rtl/bram_port_arbiter.sv
// bram_port_arbiter
//   Shares the single banked BRAM port (4 x 8-bit banks, unaligned access,
//   5-bit access code) between the instruction-fetch requester and the
//   execute/memory data requester. One request is latched at a time. The
//   addresser inputs are driven from registers, the read word is captured at
//   the end of the access cycle, and it is returned with a one-cycle ack.
//
//   Optional feature (macro ARB_ROUND_ROBIN_EN):
//     defined   - on a tie the port not granted last wins (no starvation)
//     undefined - on a tie the data port always wins (fixed priority)
//
// Ports
//   CLOCK_50           in   system clock, rising edge
//   reset              in   asynchronous active-high reset
//   if_req/if_addr     in   fetch request and byte address
//   if_ack/if_rdata    out  fetch done pulse / fetched word (held)
//   if_err             out  with if_ack: fetch address out of range
//   d_req/d_code       in   data request / {store, byte enables[3:0]}
//   d_addr/d_wdata     in   data byte address / store data
//   d_ack/d_rdata      out  data done pulse / load result (held)
//   d_err              out  with d_ack: data address out of range
//   mem_access_code    out  access code to the addresser (0 when idle)
//   mem_address        out  byte address to the addresser
//   mem_data_to_store  out  store data to the addresser
//   mem_read_data      in   read word from the addresser
//   busy               out  high whenever the FSM is not in IDLE
module bram_port_arbiter #(
  parameter int unsigned ADDR_BITS  = 18,
  parameter logic [4:0]  FETCH_CODE = 5'b01111
) (
  input  logic        CLOCK_50,
  input  logic        reset,
  input  logic        if_req,
  input  logic [31:0] if_addr,
  output logic        if_ack,
  output logic [31:0] if_rdata,
  output logic        if_err,
  input  logic        d_req,
  input  logic [4:0]  d_code,
  input  logic [31:0] d_addr,
  input  logic [31:0] d_wdata,
  output logic        d_ack,
  output logic [31:0] d_rdata,
  output logic        d_err,
  output logic [4:0]  mem_access_code,
  output logic [31:0] mem_address,
  output logic [31:0] mem_data_to_store,
  input  logic [31:0] mem_read_data,
  output logic        busy
);

  localparam int unsigned DATA_W = 32;
  localparam int unsigned CODE_W = 5;

  // Address bits at or above ADDR_BITS; any of them set means out of range.
  localparam logic [DATA_W-1:0] HI_MASK = ~((DATA_W'(1) << ADDR_BITS) - DATA_W'(1));

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_ACCESS = 2'd1,
    S_ERR    = 2'd2
  } state_t;

  state_t              r_state;
  state_t              w_state_nxt;

  // 1 = the data port owns the access in flight, 0 = fetch port.
  logic                r_gnt_d;
  logic                w_gnt_d_nxt;

  logic [CODE_W-1:0]   r_mem_code;
  logic [CODE_W-1:0]   w_mem_code_nxt;
  logic [DATA_W-1:0]   r_mem_addr;
  logic [DATA_W-1:0]   w_mem_addr_nxt;
  logic [DATA_W-1:0]   r_mem_wdata;
  logic [DATA_W-1:0]   w_mem_wdata_nxt;

  logic                r_if_ack;
  logic                w_if_ack_nxt;
  logic                r_if_err;
  logic                w_if_err_nxt;
  logic [DATA_W-1:0]   r_if_rdata;
  logic [DATA_W-1:0]   w_if_rdata_nxt;

  logic                r_d_ack;
  logic                w_d_ack_nxt;
  logic                r_d_err;
  logic                w_d_err_nxt;
  logic [DATA_W-1:0]   r_d_rdata;
  logic [DATA_W-1:0]   w_d_rdata_nxt;

  logic                r_busy;
  logic                w_busy_nxt;

  logic                w_pick_d;
  logic [DATA_W-1:0]   w_sel_addr;
  logic                w_sel_oor;

`ifdef ARB_ROUND_ROBIN_EN
  // 1 = fetch port was granted last; reset value makes data win the first tie.
  logic                r_last_fetch;
  logic                w_last_fetch_nxt;
`endif

  // Arbitration: which port an IDLE-cycle grant goes to.
  always_comb begin
    w_pick_d = 1'b0;
`ifdef ARB_ROUND_ROBIN_EN
    w_pick_d = d_req & (~if_req | r_last_fetch);
`else
    w_pick_d = d_req;
`endif
  end

  assign w_sel_addr = w_pick_d ? d_addr : if_addr;
  assign w_sel_oor  = |(w_sel_addr & HI_MASK);

  // State register.
  always_ff @(posedge CLOCK_50 or posedge reset) begin
    if (reset) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next-state and next-output logic.
  always_comb begin
    w_state_nxt     = r_state;
    w_gnt_d_nxt     = r_gnt_d;
    w_mem_code_nxt  = r_mem_code;
    w_mem_addr_nxt  = r_mem_addr;
    w_mem_wdata_nxt = r_mem_wdata;
    w_if_ack_nxt    = 1'b0;
    w_if_err_nxt    = 1'b0;
    w_if_rdata_nxt  = r_if_rdata;
    w_d_ack_nxt     = 1'b0;
    w_d_err_nxt     = 1'b0;
    w_d_rdata_nxt   = r_d_rdata;
`ifdef ARB_ROUND_ROBIN_EN
    w_last_fetch_nxt = r_last_fetch;
`endif

    case (r_state)
      S_IDLE: begin
        if (if_req || d_req) begin
          w_gnt_d_nxt = w_pick_d;
          if (w_sel_oor) begin
            w_state_nxt = S_ERR;
          end else begin
            w_state_nxt     = S_ACCESS;
            w_mem_addr_nxt  = w_sel_addr;
            w_mem_code_nxt  = w_pick_d ? d_code : FETCH_CODE;
            w_mem_wdata_nxt = w_pick_d ? d_wdata : '0;
          end
        end
      end

      S_ACCESS: begin
        // Banks run on the inverted clock, so load data is settled by now.
        if (!r_mem_code[4]) begin
          if (r_gnt_d) w_d_rdata_nxt  = mem_read_data;
          else         w_if_rdata_nxt = mem_read_data;
        end
        w_d_ack_nxt    = r_gnt_d;
        w_if_ack_nxt   = ~r_gnt_d;
        w_mem_code_nxt = '0;
`ifdef ARB_ROUND_ROBIN_EN
        w_last_fetch_nxt = ~r_gnt_d;
`endif
        w_state_nxt    = S_IDLE;
      end

      S_ERR: begin
        w_d_ack_nxt  = r_gnt_d;
        w_d_err_nxt  = r_gnt_d;
        w_if_ack_nxt = ~r_gnt_d;
        w_if_err_nxt = ~r_gnt_d;
`ifdef ARB_ROUND_ROBIN_EN
        w_last_fetch_nxt = ~r_gnt_d;
`endif
        w_state_nxt  = S_IDLE;
      end

      default: begin
        w_state_nxt    = S_IDLE;
        w_mem_code_nxt = '0;
      end
    endcase

    w_busy_nxt = (w_state_nxt != S_IDLE);
  end

  // Registered outputs and datapath.
  always_ff @(posedge CLOCK_50 or posedge reset) begin
    if (reset) begin
      r_gnt_d     <= 1'b0;
      r_mem_code  <= '0;
      r_mem_addr  <= '0;
      r_mem_wdata <= '0;
      r_if_ack    <= 1'b0;
      r_if_err    <= 1'b0;
      r_if_rdata  <= '0;
      r_d_ack     <= 1'b0;
      r_d_err     <= 1'b0;
      r_d_rdata   <= '0;
      r_busy      <= 1'b0;
    end else begin
      r_gnt_d     <= w_gnt_d_nxt;
      r_mem_code  <= w_mem_code_nxt;
      r_mem_addr  <= w_mem_addr_nxt;
      r_mem_wdata <= w_mem_wdata_nxt;
      r_if_ack    <= w_if_ack_nxt;
      r_if_err    <= w_if_err_nxt;
      r_if_rdata  <= w_if_rdata_nxt;
      r_d_ack     <= w_d_ack_nxt;
      r_d_err     <= w_d_err_nxt;
      r_d_rdata   <= w_d_rdata_nxt;
      r_busy      <= w_busy_nxt;
    end
  end

`ifdef ARB_ROUND_ROBIN_EN
  // Last-grant tracker for the round-robin tie-break.
  always_ff @(posedge CLOCK_50 or posedge reset) begin
    if (reset) begin
      r_last_fetch <= 1'b1;
    end else begin
      r_last_fetch <= w_last_fetch_nxt;
    end
  end
`endif

  assign if_ack            = r_if_ack;
  assign if_err            = r_if_err;
  assign if_rdata          = r_if_rdata;
  assign d_ack             = r_d_ack;
  assign d_err             = r_d_err;
  assign d_rdata           = r_d_rdata;
  assign mem_access_code   = r_mem_code;
  assign mem_address       = r_mem_addr;
  assign mem_data_to_store = r_mem_wdata;
  assign busy              = r_busy;

endmodule

// File: tb/tb_bram_port_arbiter.sv
// tb_bram_port_arbiter
//   Directed bench for bram_port_arbiter with a byte-array model of the
//   banked addresser (little-endian, unaligned, stores on the falling edge).
module tb_bram_port_arbiter;

  logic        CLOCK_50;
  logic        reset;
  logic        if_req;
  logic [31:0] if_addr;
  logic        if_ack;
  logic [31:0] if_rdata;
  logic        if_err;
  logic        d_req;
  logic [4:0]  d_code;
  logic [31:0] d_addr;
  logic [31:0] d_wdata;
  logic        d_ack;
  logic [31:0] d_rdata;
  logic        d_err;
  logic [4:0]  mem_access_code;
  logic [31:0] mem_address;
  logic [31:0] mem_data_to_store;
  logic [31:0] mem_read_data;
  logic        busy;

  int tests  = 0;
  int failed = 0;

  bram_port_arbiter dut (
    .CLOCK_50          (CLOCK_50),
    .reset             (reset),
    .if_req            (if_req),
    .if_addr           (if_addr),
    .if_ack            (if_ack),
    .if_rdata          (if_rdata),
    .if_err            (if_err),
    .d_req             (d_req),
    .d_code            (d_code),
    .d_addr            (d_addr),
    .d_wdata           (d_wdata),
    .d_ack             (d_ack),
    .d_rdata           (d_rdata),
    .d_err             (d_err),
    .mem_access_code   (mem_access_code),
    .mem_address       (mem_address),
    .mem_data_to_store (mem_data_to_store),
    .mem_read_data     (mem_read_data),
    .busy              (busy)
  );

  initial CLOCK_50 = 1'b0;
  always #5 CLOCK_50 = ~CLOCK_50;

  // Addresser model: 256-byte window, byte 0 at the lowest address.
  logic [7:0] mem [0:255];
  logic [7:0] a0;
  assign a0 = mem_address[7:0];
  assign mem_read_data = {mem[8'(a0 + 8'd3)], mem[8'(a0 + 8'd2)],
                          mem[8'(a0 + 8'd1)], mem[a0]};

  always @(negedge CLOCK_50) begin
    if (mem_access_code[4]) begin
      for (int i = 0; i < 4; i++) begin
        if (mem_access_code[i]) mem[8'(a0 + 8'(i))] = mem_data_to_store[8*i +: 8];
      end
    end
  end

  task automatic tick();
    @(posedge CLOCK_50);
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    tick();
    tests++; if (if_ack !== 1'b0) begin failed++; $display("FAIL reset_if_ack got %b want 0", if_ack); end
    tests++; if (d_ack !== 1'b0) begin failed++; $display("FAIL reset_d_ack got %b want 0", d_ack); end
    tests++; if (busy !== 1'b0) begin failed++; $display("FAIL reset_busy got %b want 0", busy); end
    tests++; if (mem_access_code !== 5'd0) begin failed++; $display("FAIL reset_code got %b want 00000", mem_access_code); end
    tests++; if (mem_address !== 32'd0 || mem_data_to_store !== 32'd0) begin failed++; $display("FAIL reset_mem_bus got %h/%h want 0/0", mem_address, mem_data_to_store); end
    tests++; if (if_rdata !== 32'd0 || d_rdata !== 32'd0) begin failed++; $display("FAIL reset_rdata got %h/%h want 0/0", if_rdata, d_rdata); end
    tests++; if (if_err !== 1'b0 || d_err !== 1'b0) begin failed++; $display("FAIL reset_err got %b/%b want 0/0", if_err, d_err); end
    reset = 1'b0;
    tick();
  endtask

  task automatic test_fetch();
    if_req = 1'b1; if_addr = 32'h10;
    tick();  // edge N
    tests++; if (mem_access_code !== 5'b01111) begin failed++; $display("FAIL fetch_code got %b want 01111", mem_access_code); end
    tests++; if (mem_address !== 32'h10) begin failed++; $display("FAIL fetch_addr got %h want 00000010", mem_address); end
    tests++; if (mem_data_to_store !== 32'd0) begin failed++; $display("FAIL fetch_wdata got %h want 0", mem_data_to_store); end
    tests++; if (busy !== 1'b1) begin failed++; $display("FAIL fetch_busy got %b want 1", busy); end
    tests++; if (if_ack !== 1'b0) begin failed++; $display("FAIL fetch_early_ack got %b want 0", if_ack); end
    tick();  // edge N+1
    tests++; if (if_ack !== 1'b1) begin failed++; $display("FAIL fetch_ack got %b want 1", if_ack); end
    tests++; if (if_rdata !== 32'h11223344) begin failed++; $display("FAIL fetch_rdata got %h want 11223344", if_rdata); end
    tests++; if (if_err !== 1'b0 || d_ack !== 1'b0) begin failed++; $display("FAIL fetch_err_dack got %b/%b want 0/0", if_err, d_ack); end
    tests++; if (mem_access_code !== 5'd0) begin failed++; $display("FAIL fetch_code_clear got %b want 00000", mem_access_code); end
    if_req = 1'b0;
    tick();
    tests++; if (if_ack !== 1'b0 || busy !== 1'b0) begin failed++; $display("FAIL fetch_after got ack %b busy %b want 0/0", if_ack, busy); end
  endtask

  task automatic test_store_load();
    d_req = 1'b1; d_code = 5'b10011; d_addr = 32'h21; d_wdata = 32'hAABBCCDD;
    tick();
    tests++; if (mem_access_code !== 5'b10011 || mem_data_to_store !== 32'hAABBCCDD) begin failed++; $display("FAIL store_bus got %b/%h want 10011/aabbccdd", mem_access_code, mem_data_to_store); end
    tick();
    tests++; if (d_ack !== 1'b1 || d_err !== 1'b0) begin failed++; $display("FAIL store_ack got %b err %b want 1/0", d_ack, d_err); end
    tests++; if (d_rdata !== 32'd0) begin failed++; $display("FAIL store_rdata_hold got %h want 0", d_rdata); end
    d_req = 1'b0;
    tick();
    d_req = 1'b1; d_code = 5'b01111; d_addr = 32'h21;
    tick();
    tick();
    tests++; if (d_ack !== 1'b1 || d_rdata !== 32'h2423CCDD) begin failed++; $display("FAIL load_rdata got ack %b %h want 1 2423ccdd", d_ack, d_rdata); end
    d_req = 1'b0;
    tick();
    // Store with no byte enables still completes through ACCESS.
    d_req = 1'b1; d_code = 5'b10000; d_addr = 32'h50; d_wdata = 32'hFFFFFFFF;
    tick();
    tests++; if (mem_access_code !== 5'b10000 || busy !== 1'b1) begin failed++; $display("FAIL store_be0_code got %b busy %b want 10000/1", mem_access_code, busy); end
    tick();
    tests++; if (d_ack !== 1'b1 || d_err !== 1'b0 || d_rdata !== 32'h2423CCDD) begin failed++; $display("FAIL store_be0_ack got %b/%b/%h want 1/0/2423ccdd", d_ack, d_err, d_rdata); end
    d_req = 1'b0;
    tick();
    tests++; if (mem[8'h50] !== 8'h50) begin failed++; $display("FAIL store_be0_nowrite got %h want 50", mem[8'h50]); end
  endtask

  task automatic test_tie();
    logic [3:0] order;
    int         n;
    int         n_if;
    int         both;
    logic [3:0] exp_order;
    int         exp_if;
`ifdef ARB_ROUND_ROBIN_EN
    exp_order = 4'b0101;
    exp_if    = 2;
`else
    exp_order = 4'b1111;
    exp_if    = 0;
`endif
    order = 4'b0000; n = 0; n_if = 0; both = 0;
    reset = 1'b1;
    tick();
    reset = 1'b0;
    if_req = 1'b1; if_addr = 32'h10;
    d_req  = 1'b1; d_code = 5'b01111; d_addr = 32'h10;
    for (int c = 0; c < 8; c++) begin
      tick();
      if (d_ack && if_ack) both++;
      if (if_ack) n_if++;
      if (d_ack || if_ack) begin
        if (n < 4) order[n] = d_ack;
        n++;
      end
    end
    if_req = 1'b0; d_req = 1'b0;
    tick();
    tests++; if (n !== 4 || both !== 0) begin failed++; $display("FAIL tie_count got %0d acks %0d dual want 4/0", n, both); end
    tests++; if (order !== exp_order) begin failed++; $display("FAIL tie_order got %b want %b (bit0 first, 1=D)", order, exp_order); end
    tests++; if (n_if !== exp_if) begin failed++; $display("FAIL tie_if_acks got %0d want %0d", n_if, exp_if); end
    tests++; if (d_rdata !== 32'h11223344) begin failed++; $display("FAIL tie_d_rdata got %h want 11223344", d_rdata); end
  endtask

  task automatic test_err();
    d_req = 1'b1; d_code = 5'b01111; d_addr = 32'h00040000;
    tick();
    tests++; if (mem_access_code !== 5'd0 || busy !== 1'b1) begin failed++; $display("FAIL err_code got %b busy %b want 00000/1", mem_access_code, busy); end
    tests++; if (d_ack !== 1'b0) begin failed++; $display("FAIL err_early_ack got %b want 0", d_ack); end
    tick();
    tests++; if (d_ack !== 1'b1 || d_err !== 1'b1) begin failed++; $display("FAIL err_ack got %b err %b want 1/1", d_ack, d_err); end
    tests++; if (d_rdata !== 32'h11223344 || if_ack !== 1'b0) begin failed++; $display("FAIL err_rdata got %h if_ack %b want 11223344/0", d_rdata, if_ack); end
    tests++; if (mem_access_code !== 5'd0) begin failed++; $display("FAIL err_code_after got %b want 00000", mem_access_code); end
    d_req = 1'b0;
    tick();
    // Highest in-range word address takes the normal path.
    d_req = 1'b1; d_addr = 32'h0003FFFC;
    tick();
    tests++; if (mem_access_code !== 5'b01111 || mem_address !== 32'h0003FFFC) begin failed++; $display("FAIL top_bus got %b/%h want 01111/0003fffc", mem_access_code, mem_address); end
    tick();
    tests++; if (d_ack !== 1'b1 || d_err !== 1'b0 || d_rdata !== 32'hFFFEFDFC) begin failed++; $display("FAIL top_ack got %b/%b/%h want 1/0/fffefdfc", d_ack, d_err, d_rdata); end
    d_req = 1'b0;
    tick();
  endtask

  task automatic test_reset_mid();
    int n_ack;
    n_ack = 0;
    d_req = 1'b1; d_code = 5'b11111; d_addr = 32'h40; d_wdata = 32'h55667788;
    tick();
    tests++; if (mem_access_code !== 5'b11111) begin failed++; $display("FAIL mid_code_pre got %b want 11111", mem_access_code); end
    #1;
    reset = 1'b1;
    #1;
    tests++; if (mem_access_code !== 5'd0 || busy !== 1'b0 || mem_address !== 32'd0) begin failed++; $display("FAIL mid_abort got %b busy %b addr %h want 00000/0/0", mem_access_code, busy, mem_address); end
    d_req = 1'b0;
    for (int c = 0; c < 2; c++) begin
      tick();
      if (d_ack) n_ack++;
    end
    reset = 1'b0;
    for (int c = 0; c < 2; c++) begin
      tick();
      if (d_ack) n_ack++;
    end
    tests++; if (n_ack !== 0) begin failed++; $display("FAIL mid_no_ack got %0d want 0", n_ack); end
    if_req = 1'b1; if_addr = 32'h10;
    tick();
    tick();
    tests++; if (if_ack !== 1'b1 || if_rdata !== 32'h11223344) begin failed++; $display("FAIL mid_refetch got %b %h want 1 11223344", if_ack, if_rdata); end
    if_req = 1'b0;
    tick();
  endtask

  task automatic test_drop();
    int n_ack;
    n_ack = 0;
    if_req = 1'b1; if_addr = 32'h20;
    tick();
    if_req = 1'b0;
    tests++; if (mem_access_code !== 5'b01111) begin failed++; $display("FAIL drop_code got %b want 01111", mem_access_code); end
    for (int c = 0; c < 4; c++) begin
      tick();
      if (if_ack) n_ack++;
    end
    tests++; if (n_ack !== 1) begin failed++; $display("FAIL drop_acks got %0d want 1", n_ack); end
    tests++; if (if_rdata !== 32'h23CCDD20 || busy !== 1'b0) begin failed++; $display("FAIL drop_rdata got %h busy %b want 23ccdd20/0", if_rdata, busy); end
  endtask

  initial begin
    reset = 1'b1;
    if_req = 1'b0; if_addr = '0;
    d_req = 1'b0; d_code = '0; d_addr = '0; d_wdata = '0;
    for (int i = 0; i < 256; i++) mem[i] = 8'(i);
    mem[8'h10] = 8'h44; mem[8'h11] = 8'h33; mem[8'h12] = 8'h22; mem[8'h13] = 8'h11;

    test_reset();
    test_fetch();
    test_store_load();
    test_tie();
    test_err();
    test_reset_mid();
    test_drop();

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
